// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and FSM state type for the write bank.
//   WIDTH - bits per slot
//   DEPTH - number of slots (power of two)
//   SEL_W - slot index width, log2(DEPTH)
//   LEN_W - burst length width, wide enough to hold DEPTH itself
package demux_pkg;
    localparam int WIDTH = 13;
    localparam int DEPTH = 32;
    localparam int SEL_W = 5;
    localparam int LEN_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/decoder_5_32.sv
// decoder_5_32: slot index plus enable to a one-hot write strobe.
//   i_en     - write enable; strobe is all zero when low
//   i_sel    - slot index
//   o_onehot - bit i_sel set when enabled
module decoder_5_32
    import demux_pkg::*;
(
    input  logic             i_en,
    input  logic [SEL_W-1:0] i_sel,
    output logic [DEPTH-1:0] o_onehot
);
    assign o_onehot = i_en ? (DEPTH'(1) << i_sel) : '0;
endmodule

// File: rtl/demux_write_bank.sv
// demux_write_bank: 32 registered 13-bit slots feeding the read mux tree.
// Slots load by direct write (IDLE only) or by a handshaked burst that
// auto-increments a slot pointer, wrapping 31 -> 0.
//   clock, reset      - rising-edge clock, synchronous active-high reset
//   clear             - zero all slots (IDLE only, beats wr_en)
//   wr_en/sel/data    - direct write (IDLE only)
//   burst_start/base/len - begin burst; len 0 = no-op, >32 saturates
//   in_valid/in_data  - burst word stream; in_ready handshake
//   busy              - high in BURST
//   burst_done        - one-cycle pulse after last burst word is written
//   slots             - slot k at bits [13k+12:13k]
// Optional macro DEMUX_WRITE_BANK_VALID_EN adds slot_valid[31:0]: bit k set
// when slot k is written, cleared by clear or reset.
module demux_write_bank
    import demux_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [SEL_W-1:0]       wr_sel,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   burst_start,
    input  logic [SEL_W-1:0]       burst_base,
    input  logic [LEN_W-1:0]       burst_len,
    input  logic                   in_valid,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   in_ready,
    output logic                   busy,
    output logic                   burst_done,
    output logic [WIDTH*DEPTH-1:0] slots
`ifdef DEMUX_WRITE_BANK_VALID_EN
    ,
    output logic [DEPTH-1:0]       slot_valid
`endif
);
    state_t                        r_state, w_state_nxt;
    logic [SEL_W-1:0]              r_ptr;
    logic [LEN_W-1:0]              r_rem;
    logic                          r_busy, r_done;
    logic [DEPTH-1:0][WIDTH-1:0]   r_slots;

    logic                          w_idle, w_accept, w_clear, w_direct, w_start;
    logic [LEN_W-1:0]              w_len_sat;
    logic [SEL_W-1:0]              w_idx;
    logic [WIDTH-1:0]              w_data;
    logic [DEPTH-1:0]              w_strobe;

    assign w_idle    = (r_state == IDLE);
    assign w_accept  = (r_state == BURST) && in_valid;
    assign w_clear   = w_idle && clear;
    // clear wins over a same-cycle direct write
    assign w_direct  = w_idle && wr_en && !clear;
    assign w_start   = w_idle && burst_start && (burst_len != '0);
    assign w_len_sat = (burst_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : burst_len;

    // Direct and burst paths are mutually exclusive by state, so one decoder
    // serves both through a mux on index and data.
    assign w_idx  = w_accept ? r_ptr   : wr_sel;
    assign w_data = w_accept ? in_data : wr_data;

    decoder_5_32 u_dec (
        .i_en     (w_accept | w_direct),
        .i_sel    (w_idx),
        .o_onehot (w_strobe)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = BURST;
            BURST:   if (w_accept && r_rem == LEN_W'(1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // status flags registered from next state so outputs are flop-driven
            r_busy  <= (w_state_nxt == BURST);
            r_done  <= (w_state_nxt == DONE);
            if (w_start) begin
                r_ptr <= burst_base;
                r_rem <= w_len_sat;
            end else if (w_accept) begin
                r_ptr <= r_ptr + SEL_W'(1);
                r_rem <= r_rem - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || w_clear) begin
            r_slots <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++)
                if (w_strobe[k]) r_slots[k] <= w_data;
        end
    end

`ifdef DEMUX_WRITE_BANK_VALID_EN
    logic [DEPTH-1:0] r_valid;
    always_ff @(posedge clock) begin
        if (reset || w_clear) r_valid <= '0;
        else                  r_valid <= r_valid | w_strobe;
    end
    assign slot_valid = r_valid;
`endif

    assign slots      = r_slots;
    assign in_ready   = r_busy;
    assign busy       = r_busy;
    assign burst_done = r_done;
endmodule

// File: tb/tb_demux_write_bank.sv
// Scoreboard bench for demux_write_bank: stimulus pushes expected snapshots
// and expected done cycles into queues; the monitor pops and compares on the
// falling edge.
module tb_demux_write_bank;
    logic          clock = 1'b0;
    logic          reset, clear, wr_en, burst_start, in_valid;
    logic [4:0]    wr_sel, burst_base;
    logic [12:0]   wr_data, in_data;
    logic [5:0]    burst_len;
    logic          in_ready, busy, burst_done;
    logic [415:0]  slots;
    logic [31:0]   slot_valid;

    always #5 clock = ~clock;

    demux_write_bank dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_data     (wr_data),
        .burst_start (burst_start),
        .burst_base  (burst_base),
        .burst_len   (burst_len),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .burst_done  (burst_done),
        .slots       (slots)
`ifdef DEMUX_WRITE_BANK_VALID_EN
        ,
        .slot_valid  (slot_valid)
`endif
    );
`ifndef DEMUX_WRITE_BANK_VALID_EN
    assign slot_valid = '0;
`endif

    typedef struct {
        int           cyc;
        int           tag;
        logic [415:0] slots;
        logic         busy;
        logic [31:0]  vld;
    } exp_t;

    exp_t          q[$];
    int            done_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            tag = 0;
    logic [12:0]   m [32];
    logic [31:0]   mv;
    logic          exp_busy;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [415:0] pack_model();
        logic [415:0] p;
        for (int k = 0; k < 32; k++) p[k*13 +: 13] = m[k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic snap();
        exp_t e;
        e.cyc   = cyc;
        e.tag   = tag;
        e.slots = pack_model();
        e.busy  = exp_busy;
        e.vld   = mv;
        q.push_back(e);
        tag++;
    endtask

    task automatic model_zero();
        for (int k = 0; k < 32; k++) m[k] = '0;
        mv = '0;
    endtask

    task automatic wr(input int sel, input int data);
        wr_en = 1'b1; wr_sel = 5'(sel); wr_data = 13'(data);
        tick();
        wr_en = 1'b0;
        m[sel] = 13'(data);
        mv[sel] = 1'b1;
        snap();
    endtask

    task automatic start_burst(input int base, input int len);
        burst_start = 1'b1; burst_base = 5'(base); burst_len = 6'(len);
        tick();
        burst_start = 1'b0;
        exp_busy = 1'b1;
        snap();
    endtask

    task automatic feed(input int base, input int idx, input int data, input bit last);
        in_valid = 1'b1; in_data = 13'(data);
        tick();
        in_valid = 1'b0;
        m[(base + idx) % 32]  = 13'(data);
        mv[(base + idx) % 32] = 1'b1;
        if (last) begin
            exp_busy = 1'b0;
            done_q.push_back(cyc);
        end
        snap();
    endtask

    // Monitor: compare snapshots due this cycle and every done pulse.
    always @(negedge clock) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if (slots !== e.slots) begin
                n_bad++;
                $display("FAIL slots#%0d cyc %0d: got %h want %h", e.tag, cyc, slots, e.slots);
            end
            n_cmp++;
            if (busy !== e.busy || in_ready !== e.busy) begin
                n_bad++;
                $display("FAIL busy#%0d cyc %0d: busy %b in_ready %b want %b", e.tag, cyc, busy, in_ready, e.busy);
            end
`ifdef DEMUX_WRITE_BANK_VALID_EN
            n_cmp++;
            if (slot_valid !== e.vld) begin
                n_bad++;
                $display("FAIL slot_valid#%0d cyc %0d: got %h want %h", e.tag, cyc, slot_valid, e.vld);
            end
`endif
        end
        if (burst_done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL done_unexpected cyc %0d: got 1 want 0", cyc);
            end else begin
                int dc;
                dc = done_q.pop_front();
                if (dc != cyc) begin
                    n_bad++;
                    $display("FAIL done_cycle: got %0d want %0d", cyc, dc);
                end
            end
        end
    end

    int pat [5] = '{1, 0, 0, 1, 1};
    int w3  [3] = '{13'h111, 13'h222, 13'h333};

    initial begin
        int k;
        reset = 1'b1; clear = 0; wr_en = 0; wr_sel = 0; wr_data = 0;
        burst_start = 0; burst_base = 0; burst_len = 0; in_valid = 0; in_data = 0;
        model_zero();
        exp_busy = 1'b0;
        tick(); tick();
        reset = 1'b0;
        snap();

        // direct write slot 7
        wr(7, 13'h1ABC);

        // burst base 30 len 4, wraps 31 -> 0
        start_burst(30, 4);
        for (int i = 0; i < 4; i++) feed(30, i, i + 1, i == 3);
        tick(); snap();

        // burst len 3 with in_valid gaps
        start_burst(10, 3);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = pat[i][0]; in_data = 13'(w3[k < 3 ? k : 2]);
            tick();
            in_valid = 1'b0;
            if (pat[i] != 0) begin
                m[10 + k] = 13'(w3[k]); mv[10 + k] = 1'b1; k++;
                if (k == 3) begin exp_busy = 1'b0; done_q.push_back(cyc); end
            end
            snap();
        end
        tick(); snap();

        // control inputs ignored during BURST and DONE
        wr(5, 13'h1555);
        start_burst(20, 2);
        wr_en = 1; wr_sel = 5; wr_data = 13'h0FFF; clear = 1; burst_start = 1; burst_len = 6'd5;
        tick(); snap();
        wr_en = 0; clear = 0; burst_start = 0;
        feed(20, 0, 13'h0AA, 0);
        feed(20, 1, 13'h0BB, 1);
        wr_en = 1; wr_sel = 6; wr_data = 13'h0666; clear = 1; burst_start = 1; burst_len = 6'd3;
        tick(); snap();
        wr_en = 0; clear = 0; burst_start = 0;
        tick(); snap();

        // wr_en + burst_start with len 0: write only
        wr_en = 1; wr_sel = 8; wr_data = 13'h0888; burst_start = 1; burst_len = 0;
        tick();
        wr_en = 0; burst_start = 0;
        m[8] = 13'h0888; mv[8] = 1'b1; snap();
        tick(); snap();

        // wr_en + burst_start with len 2: write and burst
        wr_en = 1; wr_sel = 9; wr_data = 13'h0999; burst_start = 1; burst_base = 14; burst_len = 2;
        tick();
        wr_en = 0; burst_start = 0;
        m[9] = 13'h0999; mv[9] = 1'b1; exp_busy = 1'b1; snap();
        feed(14, 0, 13'h141, 0);
        feed(14, 1, 13'h142, 1);
        tick(); snap();

        // clear beats same-cycle write
        clear = 1; wr_en = 1; wr_sel = 7; wr_data = 13'h1FFF;
        tick();
        clear = 0; wr_en = 0;
        model_zero(); snap();

        // len 40 saturates to 32, base 3 wraps through 0
        start_burst(3, 40);
        for (int i = 0; i < 32; i++) feed(3, i, 13'h40 + i, i == 31);
        tick(); snap();

        // reset mid-burst: no done pulse, bank zeroed
        start_burst(0, 4);
        feed(0, 0, 13'h011, 0);
        feed(0, 1, 13'h022, 0);
        reset = 1;
        tick();
        reset = 0;
        model_zero(); exp_busy = 1'b0; snap();
        tick(); snap();
        tick(); snap();
        wr(2, 13'h0222);

        tick(); tick();
        n_cmp++;
        if (q.size() != 0 || done_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: snapshots left %0d done left %0d want 0 0", q.size(), done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
